alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes the low 16 bits of a signed 16x16 product. It computes the product by time-multiplexing the shared 16-bit ALU, so it has no adder of its own. It drives the ALU's inA/inB/inC/opc inputs and captures outW, using opcode 2 (A+B+cin) for shift-and-add. It sits beside the ALU in the datapath and owns the ALU's input bus while busy; the parent muxes ALU ownership on busy.

---
 rtl/alu_mul_sequencer_pkg.sv | 25 ++
 rtl/alu_mul_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer.
// Holds the controller state encoding, the ALU opcode map (the opcodes the
// sequencer drives on the shared ALU bus) and the default datapath width.
package alu_seq_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // ALU opcodes
  localparam logic [2:0] OPC_NEG    = 3'd0;
  localparam logic [2:0] OPC_INC    = 3'd1;
  localparam logic [2:0] OPC_ADD    = 3'd2;  // A + B + cin
  localparam logic [2:0] OPC_ADDSHR = 3'd3;
  localparam logic [2:0] OPC_AND    = 3'd4;
  localparam logic [2:0] OPC_OR     = 3'd5;
  localparam logic [2:0] OPC_CAT    = 3'd6;
  localparam logic [2:0] OPC_IDLE   = 3'd7;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle signed WIDTHxWIDTH multiplier (low WIDTH bits of the product)
// that borrows the shared ALU instead of owning an adder. Shift-and-add over
// ITER multiplier bits, two cycles per bit (ADD then DBL), fixed latency.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, opA, opB   request and operands (sampled only when idle)
//   busy, done        busy while not idle; done pulses for one cycle in DONE
//   result, zer, neg  product and its flags, updated only when leaving DONE
//   alu_inA/inB/inC/opc  drive the shared ALU while busy
//   alu_outW          combinational ALU result returned in the same cycle
module alu_mul_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zer,
  output logic             neg,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic             alu_inC,
  output logic [2:0]       alu_opc,
  input  logic [WIDTH-1:0] alu_outW
);

  localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [3:0]       cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, status and ALU bus. The bus is parked on OPC_IDLE with zero
  // operands whenever the sequencer is not actually using the adder.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    alu_opc   = OPC_IDLE;
    alu_inA   = '0;
    alu_inB   = '0;
    alu_inC   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        if (mp[0]) begin
          alu_opc = OPC_ADD;
          alu_inA = acc;
          alu_inB = mc;
        end
        state_nxt = DBL;
      end
      DBL: begin
        alu_opc = OPC_ADD;
        alu_inA = mc;
        alu_inB = mc;
        state_nxt = (cnt == CNT_LAST) ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      cnt    <= '0;
      result <= '0;
      zer    <= 1'b1;
      neg    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            mc  <= opA;
            mp  <= opB;
            cnt <= '0;
          end
        end
        ADD: begin
          if (mp[0]) acc <= alu_outW;
        end
        DBL: begin
          mc <= alu_outW;
          mp <= mp >> 1;
          if (cnt != CNT_LAST) cnt <= cnt + 4'd1;
        end
        DONE: begin
          result <= acc;
          zer    <= (acc == '0);
          neg    <= acc[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared
// ALU closing the loop. Cycle k is the clock period after edge k, where edge 0
// is the edge that accepts start; outputs are sampled on the falling edge.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zer;
  logic         neg;
  logic [W-1:0] alu_inA;
  logic [W-1:0] alu_inB;
  logic         alu_inC;
  logic [2:0]   alu_opc;
  logic [W-1:0] alu_outW;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_mul_sequencer #(.WIDTH(W), .ITER(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zer      (zer),
    .neg      (neg),
    .alu_inA  (alu_inA),
    .alu_inB  (alu_inB),
    .alu_inC  (alu_inC),
    .alu_opc  (alu_opc),
    .alu_outW (alu_outW)
  );

  // Shared ALU model
  always_comb begin
    alu_outW = '0;
    case (alu_opc)
      3'd0: alu_outW = -alu_inA;
      3'd1: alu_outW = alu_inA + 16'd1;
      3'd2: alu_outW = alu_inA + alu_inB + {15'd0, alu_inC};
      3'd3: alu_outW = (alu_inA + alu_inB + {15'd0, alu_inC}) >> 1;
      3'd4: alu_outW = alu_inA & alu_inB;
      3'd5: alu_outW = alu_inA | alu_inB;
      3'd6: alu_outW = {alu_inA[7:0], alu_inB[7:0]};
      default: alu_outW = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue one operation and follow it cycle by cycle to cycle 34.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    logic [W-1:0] prev;
    prev = result;
    @(negedge clk);
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        opA   = ~a;  // later operand changes must not matter
        opB   = ~b;
      end
      check("busy", busy, (k <= 33));
      check("done", done, (k == 33));
      if (k <= 33) check("result_hold", result, prev);
    end
    check("result", result, exp);
    check("zer", zer, (exp == '0));
    check("neg", neg, exp[W-1]);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zer", zer, 1);
    check("rst_neg", neg, 0);
    check("rst_opc", alu_opc, 7);
    rst_n = 1'b1;
    @(negedge clk);

    // Main function
    run_op(16'h0003, 16'h0005, 16'h000F);
    run_op(16'hFFFC, 16'h0007, 16'hFFE4);
    run_op(16'hFFFF, 16'hFFFF, 16'h0001);
    run_op(16'h0100, 16'h0100, 16'h0000);
    run_op(16'h1234, 16'h0003, 16'h369C);
    run_op(16'h0000, 16'h1234, 16'h0000);
    run_op(16'h7FFF, 16'h0002, 16'hFFFE);

    // ALU bus ownership with a single multiplier bit set
    @(negedge clk);
    opA   = 16'h0003;
    opB   = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 34; k++) begin
      logic [W-1:0] mc_exp;
      @(negedge clk);
      start = 1'b0;
      if (k <= 32 && (k % 2) == 1) begin
        if (k == 1) begin
          check("bus_add1_opc", alu_opc, 2);
          check("bus_add1_inA", alu_inA, 0);
          check("bus_add1_inB", alu_inB, 16'h0003);
        end else begin
          check("bus_addn_opc", alu_opc, 7);
          check("bus_addn_inA", alu_inA, 0);
          check("bus_addn_inB", alu_inB, 0);
        end
      end else if (k <= 32) begin
        mc_exp = 16'h0003 << (k / 2 - 1);
        check("bus_dbl_opc", alu_opc, 2);
        check("bus_dbl_inA", alu_inA, mc_exp);
        check("bus_dbl_inB", alu_inB, mc_exp);
        check("bus_dbl_inC", alu_inC, 0);
      end else begin
        check("bus_park_opc", alu_opc, 7);
      end
    end
    check("bus_result", result, 16'h0003);

    // start while busy is ignored; start at cycle 34 is accepted
    @(negedge clk);
    opA   = 16'h0003;
    opB   = 16'h0005;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (k == 34) check("ign_result", result, 16'h000F);
      if (k >= 5 && k <= 20) begin
        start = 1'b1;
        opA   = 16'h0007;
        opB   = 16'h0009;
      end else if (k == 34) begin
        start = 1'b1;
        opA   = 16'h0006;
        opB   = 16'h0007;
      end else begin
        start = 1'b0;
      end
      if (k == 33 || k == 67 || k == 21 || k == 50) check("ign_done", done, (k == 33 || k == 67));
      if (k == 34) check("acc_busy", busy, 0);
      if (k == 35) check("acc_busy2", busy, 1);
    end
    check("ign_second", result, 16'h002A);

    // Reset mid-operation
    @(negedge clk);
    opA   = 16'h1234;
    opB   = 16'h0003;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_result", result, 0);
    check("mrst_zer", zer, 1);
    begin
      int unsigned seen_done;
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("mrst_no_done", seen_done, 0);
    end
    run_op(16'hFFFC, 16'h0007, 16'hFFE4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
